// File: rtl/pg2pp_pkg.sv
// Shared definitions for the pixel-FIFO to parallel-pixel read controller:
// FSM state encoding and default video timing constants.
package pg2pp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    // 1080p-style defaults, counted in FIFO words and lines
    localparam logic [7:0]  DEF_RGB_PORT    = 8'd1;
    localparam logic [15:0] DEF_H_ACTIVE    = 16'd1920;
    localparam logic [15:0] DEF_H_BLANK     = 16'd280;
    localparam logic [15:0] DEF_HS_WIDTH    = 16'd44;
    localparam logic [15:0] DEF_V_ACTIVE    = 16'd1080;
    localparam logic [15:0] DEF_V_BLANK     = 16'd45;
    localparam logic [15:0] DEF_VS_WIDTH    = 16'd5;
    localparam logic [8:0]  DEF_FILL_THRESH = 9'd64;

endpackage

// File: rtl/pg2pp_timing_gen.sv
// Horizontal/vertical word and line counters with active/sync decode.
// Counters run only while 'run' is high and are held at zero otherwise.
module pg2pp_timing_gen
    import pg2pp_pkg::*;
#(
    parameter logic [15:0] H_ACTIVE = DEF_H_ACTIVE,
    parameter logic [15:0] H_BLANK  = DEF_H_BLANK,
    parameter logic [15:0] HS_WIDTH = DEF_HS_WIDTH,
    parameter logic [15:0] V_ACTIVE = DEF_V_ACTIVE,
    parameter logic [15:0] V_BLANK  = DEF_V_BLANK,
    parameter logic [15:0] VS_WIDTH = DEF_VS_WIDTH
) (
    input  logic        rd_clk,
    input  logic        rst,
    input  logic        run,
    output logic [15:0] h_cnt,
    output logic [15:0] v_cnt,
    output logic        de_i,
    output logic        hs_i,
    output logic        vs_i,
    output logic        eof
);

    localparam logic [15:0] H_TOTAL = H_ACTIVE + H_BLANK;
    localparam logic [15:0] V_TOTAL = V_ACTIVE + V_BLANK;
    localparam logic [15:0] H_LAST  = H_TOTAL - 16'd1;
    localparam logic [15:0] V_LAST  = V_TOTAL - 16'd1;
    localparam logic [15:0] HS_END  = H_ACTIVE + HS_WIDTH;
    localparam logic [15:0] VS_END  = V_ACTIVE + VS_WIDTH;

    logic h_wrap;
    logic v_wrap;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    always_ff @(posedge rd_clk) begin
        if (rst || !run) begin
            h_cnt <= 16'd0;
        end else if (h_wrap) begin
            h_cnt <= 16'd0;
        end else begin
            h_cnt <= h_cnt + 16'd1;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rst || !run) begin
            v_cnt <= 16'd0;
        end else if (h_wrap) begin
            if (v_wrap) begin
                v_cnt <= 16'd0;
            end else begin
                v_cnt <= v_cnt + 16'd1;
            end
        end
    end

    // Decodes are qualified by run: the held-at-zero counters would
    // otherwise look like the first active word of a frame.
    assign de_i = run && (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);
    assign hs_i = run && (h_cnt >= H_ACTIVE) && (h_cnt < HS_END);
    assign vs_i = run && (v_cnt >= V_ACTIVE) && (v_cnt < VS_END);
    assign eof  = run && h_wrap && v_wrap;

endmodule

// File: rtl/pg2pp_rd_ctrl.sv
// Reads pixel words from a FIFO and emits them as parallel video with
// Vs/Hs/De timing; waits for a fill level before starting each frame.
module pg2pp_rd_ctrl
    import pg2pp_pkg::*;
#(
    parameter logic [7:0]  RGB_PORT    = DEF_RGB_PORT,
    parameter logic [15:0] H_ACTIVE    = DEF_H_ACTIVE,
    parameter logic [15:0] H_BLANK     = DEF_H_BLANK,
    parameter logic [15:0] HS_WIDTH    = DEF_HS_WIDTH,
    parameter logic [15:0] V_ACTIVE    = DEF_V_ACTIVE,
    parameter logic [15:0] V_BLANK     = DEF_V_BLANK,
    parameter logic [15:0] VS_WIDTH    = DEF_VS_WIDTH,
    parameter logic [8:0]  FILL_THRESH = DEF_FILL_THRESH
) (
    input  logic                      rd_clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [8:0]                rd_data_count,
    input  logic                      fifo_empty,
    input  logic                      fifo_valid,
    input  logic [RGB_PORT*24-1:0]    fifo_dout,
    output logic                      fifo_rd_en,
    output logic                      Vs_out,
    output logic                      Hs_out,
    output logic                      De_out,
    output logic [RGB_PORT*24-1:0]    Dout,
    output logic                      underrun,
    output logic                      frame_done,
    output state_t                    state,
    output logic [15:0]               h_cnt,
    output logic [15:0]               v_cnt
);

    // FIFO handshake: fifo_rd_en is a single-cycle read strobe issued only
    // when the FIFO is not empty; the word it requests is presented one
    // cycle later with fifo_valid high, and is only taken when both the
    // registered strobe and fifo_valid agree.

    state_t state_q;
    state_t state_d;
    logic   run;
    logic   de_i;
    logic   hs_i;
    logic   vs_i;
    logic   eof;
    logic   uf_frame;
    logic   rd_miss;
    logic   rd_issued_q;

    assign run   = (state_q == RUN);
    assign state = state_q;

    pg2pp_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_BLANK  (H_BLANK),
        .HS_WIDTH (HS_WIDTH),
        .V_ACTIVE (V_ACTIVE),
        .V_BLANK  (V_BLANK),
        .VS_WIDTH (VS_WIDTH)
    ) u_timing (
        .rd_clk (rd_clk),
        .rst    (rst),
        .run    (run),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .de_i   (de_i),
        .hs_i   (hs_i),
        .vs_i   (vs_i),
        .eof    (eof)
    );

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Once running, a frame always completes; enable and the underrun
    // history are only consulted on the last word of the frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (rd_data_count >= FILL_THRESH) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (eof) begin
                    if (!enable) begin
                        state_d = IDLE;
                    end else if (uf_frame) begin
                        state_d = FILL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fifo_rd_en = de_i && !fifo_empty && run;
    assign rd_miss    = de_i && fifo_empty && run;

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            uf_frame <= 1'b0;
        end else if (eof) begin
            uf_frame <= 1'b0;
        end else if (rd_miss) begin
            uf_frame <= 1'b1;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (rd_miss) begin
            underrun <= 1'b1;
        end
    end

    // One register stage on timing lines matches the FIFO read latency.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            Vs_out      <= 1'b0;
            Hs_out      <= 1'b0;
            De_out      <= 1'b0;
            frame_done  <= 1'b0;
            rd_issued_q <= 1'b0;
        end else begin
            Vs_out      <= vs_i;
            Hs_out      <= hs_i;
            De_out      <= de_i;
            frame_done  <= eof;
            rd_issued_q <= fifo_rd_en;
        end
    end

    assign Dout = (rd_issued_q && fifo_valid) ? fifo_dout : '0;

endmodule

// File: tb/tb_pg2pp_rd_ctrl.sv
// Directed bench for pg2pp_rd_ctrl using a small 8x4 active / 12x6 total raster.
module tb_pg2pp_rd_ctrl;
    import pg2pp_pkg::*;

    localparam int H_TOT = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [8:0]  rd_data_count = 9'd0;
    logic        force_empty = 1'b0;
    logic        fifo_empty;
    logic        fifo_valid = 1'b0;
    logic [23:0] fifo_dout = 24'd0;
    logic        fifo_rd_en;
    logic        Vs_out;
    logic        Hs_out;
    logic        De_out;
    logic [23:0] Dout;
    logic        underrun;
    logic        frame_done;
    state_t      state;
    logic [15:0] h_cnt;
    logic [15:0] v_cnt;

    logic [23:0] mem [0:255];
    logic [7:0]  wr_ptr = 8'd0;
    logic [7:0]  rd_ptr = 8'd0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pg2pp_rd_ctrl #(
        .RGB_PORT    (8'd1),
        .H_ACTIVE    (16'd8),
        .H_BLANK     (16'd4),
        .HS_WIDTH    (16'd2),
        .V_ACTIVE    (16'd4),
        .V_BLANK     (16'd2),
        .VS_WIDTH    (16'd1),
        .FILL_THRESH (9'd4)
    ) dut (
        .rd_clk        (clk),
        .rst           (rst),
        .enable        (enable),
        .rd_data_count (rd_data_count),
        .fifo_empty    (fifo_empty),
        .fifo_valid    (fifo_valid),
        .fifo_dout     (fifo_dout),
        .fifo_rd_en    (fifo_rd_en),
        .Vs_out        (Vs_out),
        .Hs_out        (Hs_out),
        .De_out        (De_out),
        .Dout          (Dout),
        .underrun      (underrun),
        .frame_done    (frame_done),
        .state         (state),
        .h_cnt         (h_cnt),
        .v_cnt         (v_cnt)
    );

    // FIFO response model: first-word-fall-through off, one-cycle read latency
    assign fifo_empty = (rd_ptr == wr_ptr) || force_empty;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout  <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 8'd1;
            fifo_valid <= 1'b1;
        end else begin
            fifo_valid <= 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        enable = 1'b0;
        force_empty = 1'b0;
        rd_data_count = 9'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load_fifo(input int n, input int base);
        wr_ptr = rd_ptr;
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = 24'(base + i);
            wr_ptr = wr_ptr + 8'd1;
        end
    endtask

    task automatic start_frame;
        int t;
        t = 0;
        rd_data_count = 9'd4;
        enable = 1'b1;
        do begin
            tick();
            t++;
        end while (state !== RUN && t < 8);
        n_vec++;
        if (state !== RUN) begin
            n_err++;
            $display("FAIL start_timeout: state got %0d expected %0d", state, RUN);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        enable = 1'b1;
        rd_data_count = 9'd100;
        tick();
        n_vec++; if (state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", state, IDLE); end
        n_vec++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
        n_vec++; if ({Vs_out, Hs_out, De_out} !== 3'b000) begin n_err++; $display("FAIL reset_sync: got %b expected 000", {Vs_out, Hs_out, De_out}); end
        n_vec++; if (Dout !== 24'd0) begin n_err++; $display("FAIL reset_dout: got %0h expected 0", Dout); end
        n_vec++; if ({underrun, frame_done} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b expected 00", {underrun, frame_done}); end
        do_reset();
    endtask

    task automatic test_fill_gate;
        int n_on;
        logic first_on;
        do_reset();
        load_fifo(32, 1);
        rd_data_count = 9'd3;
        enable = 1'b1;
        tick();
        n_vec++; if (state !== FILL) begin n_err++; $display("FAIL fill_enter: got %0d expected %0d", state, FILL); end
        tick();
        tick();
        n_vec++; if (state !== FILL) begin n_err++; $display("FAIL fill_hold: got %0d expected %0d", state, FILL); end
        n_vec++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL fill_rd_en: got %b expected 0", fifo_rd_en); end
        rd_data_count = 9'd4;
        tick();
        n_vec++; if (state !== RUN) begin n_err++; $display("FAIL fill_to_run: got %0d expected %0d", state, RUN); end
        first_on = fifo_rd_en;
        n_on = 0;
        for (int k = 0; k < H_TOT; k++) begin
            if (fifo_rd_en === 1'b1) n_on++;
            tick();
        end
        n_vec++; if (first_on !== 1'b1) begin n_err++; $display("FAIL fill_first_rd: got %b expected 1", first_on); end
        n_vec++; if (n_on != 8) begin n_err++; $display("FAIL fill_rd_count: got %0d expected 8", n_on); end
    endtask

    task automatic test_alignment;
        int j;
        int h;
        int v;
        int next_val;
        int n_de;
        int n_hs;
        int n_vs;
        int n_fd;
        logic e_de;
        logic e_hs;
        logic e_vs;
        logic e_fd;
        logic [23:0] e_dout;
        do_reset();
        load_fifo(32, 1);
        start_frame();
        next_val = 1;
        n_de = 0; n_hs = 0; n_vs = 0; n_fd = 0;
        for (int k = 0; k <= 72; k++) begin
            e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_fd = 1'b0; e_dout = 24'd0;
            if (k > 0) begin
                j = k - 1;
                h = j % H_TOT;
                v = j / H_TOT;
                e_de = (h < 8) && (v < 4);
                e_hs = (h == 8) || (h == 9);
                e_vs = (v == 4);
                e_fd = (j == 71);
                if (e_de) begin
                    e_dout = 24'(next_val);
                    next_val++;
                end
            end
            n_vec++; if (De_out !== e_de) begin n_err++; $display("FAIL align_de k=%0d: got %b expected %b", k, De_out, e_de); end
            n_vec++; if (Hs_out !== e_hs) begin n_err++; $display("FAIL align_hs k=%0d: got %b expected %b", k, Hs_out, e_hs); end
            n_vec++; if (Vs_out !== e_vs) begin n_err++; $display("FAIL align_vs k=%0d: got %b expected %b", k, Vs_out, e_vs); end
            n_vec++; if (frame_done !== e_fd) begin n_err++; $display("FAIL align_fd k=%0d: got %b expected %b", k, frame_done, e_fd); end
            n_vec++; if (Dout !== e_dout) begin n_err++; $display("FAIL align_dout k=%0d: got %0d expected %0d", k, Dout, e_dout); end
            if (De_out === 1'b1) n_de++;
            if (Hs_out === 1'b1) n_hs++;
            if (Vs_out === 1'b1) n_vs++;
            if (frame_done === 1'b1) n_fd++;
            if (k < 72) tick();
        end
        n_vec++; if (n_de != 32) begin n_err++; $display("FAIL align_de_total: got %0d expected 32", n_de); end
        n_vec++; if (n_hs != 12) begin n_err++; $display("FAIL align_hs_total: got %0d expected 12", n_hs); end
        n_vec++; if (n_vs != 12) begin n_err++; $display("FAIL align_vs_total: got %0d expected 12", n_vs); end
        n_vec++; if (n_fd != 1) begin n_err++; $display("FAIL align_fd_total: got %0d expected 1", n_fd); end
        n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL align_no_underrun: got %b expected 0", underrun); end
    endtask

    task automatic test_underrun;
        do_reset();
        load_fifo(32, 1);
        start_frame();
        tick();
        tick();
        force_empty = 1'b1;
        #1;
        n_vec++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL uf_rd_en: got %b expected 0", fifo_rd_en); end
        tick();
        force_empty = 1'b0;
        n_vec++; if (De_out !== 1'b1) begin n_err++; $display("FAIL uf_de: got %b expected 1", De_out); end
        n_vec++; if (Dout !== 24'd0) begin n_err++; $display("FAIL uf_dout_zero: got %0d expected 0", Dout); end
        n_vec++; if (underrun !== 1'b1) begin n_err++; $display("FAIL uf_flag: got %b expected 1", underrun); end
        tick();
        n_vec++; if (Dout !== 24'd3) begin n_err++; $display("FAIL uf_next_word: got %0d expected 3", Dout); end
        for (int k = 5; k <= 72; k++) tick();
        n_vec++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL uf_frame_done: got %b expected 1", frame_done); end
        n_vec++; if (state !== FILL) begin n_err++; $display("FAIL uf_refill: got %0d expected %0d", state, FILL); end
        n_vec++; if (underrun !== 1'b1) begin n_err++; $display("FAIL uf_sticky: got %b expected 1", underrun); end
        enable = 1'b0;
        tick();
        n_vec++; if (state !== IDLE) begin n_err++; $display("FAIL uf_fill_drop: got %0d expected %0d", state, IDLE); end
        n_vec++; if (underrun !== 1'b1) begin n_err++; $display("FAIL uf_sticky_idle: got %b expected 1", underrun); end
        do_reset();
        n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL uf_cleared: got %b expected 0", underrun); end
    endtask

    task automatic test_enable_drop;
        int n_de;
        do_reset();
        load_fifo(32, 1);
        start_frame();
        n_de = 0;
        for (int k = 1; k <= 72; k++) begin
            tick();
            if (De_out === 1'b1) n_de++;
            if (k == 12) enable = 1'b0;
            if (k == 71) begin
                n_vec++; if (state !== RUN) begin n_err++; $display("FAIL drop_still_run: got %0d expected %0d", state, RUN); end
            end
        end
        n_vec++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL drop_frame_done: got %b expected 1", frame_done); end
        n_vec++; if (state !== IDLE) begin n_err++; $display("FAIL drop_idle: got %0d expected %0d", state, IDLE); end
        n_vec++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL drop_rd_en: got %b expected 0", fifo_rd_en); end
        n_vec++; if (n_de != 32) begin n_err++; $display("FAIL drop_de_total: got %0d expected 32", n_de); end
        tick();
        n_vec++; if (state !== IDLE) begin n_err++; $display("FAIL drop_stay_idle: got %0d expected %0d", state, IDLE); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        load_fifo(32, 1);
        start_frame();
        for (int k = 1; k <= 29; k++) tick();
        n_vec++; if (h_cnt !== 16'd5 || v_cnt !== 16'd2) begin n_err++; $display("FAIL mid_position: got h=%0d v=%0d expected h=5 v=2", h_cnt, v_cnt); end
        rst = 1'b1;
        tick();
        n_vec++; if (state !== IDLE) begin n_err++; $display("FAIL mid_state: got %0d expected %0d", state, IDLE); end
        n_vec++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL mid_rd_en: got %b expected 0", fifo_rd_en); end
        n_vec++; if ({Vs_out, Hs_out, De_out, frame_done, underrun} !== 5'b00000) begin n_err++; $display("FAIL mid_outputs: got %b expected 00000", {Vs_out, Hs_out, De_out, frame_done, underrun}); end
        n_vec++; if (Dout !== 24'd0) begin n_err++; $display("FAIL mid_dout: got %0d expected 0", Dout); end
        n_vec++; if (h_cnt !== 16'd0 || v_cnt !== 16'd0) begin n_err++; $display("FAIL mid_counters: got h=%0d v=%0d expected 0 0", h_cnt, v_cnt); end
        rst = 1'b0;
        enable = 1'b1;
        tick();
        n_vec++; if (state !== FILL) begin n_err++; $display("FAIL mid_restart: got %0d expected %0d", state, FILL); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        load_fifo(80, 1);
        start_frame();
        for (int k = 1; k <= 73; k++) begin
            tick();
            if (k == 72) begin
                n_vec++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL b2b_frame_done: got %b expected 1", frame_done); end
                n_vec++; if (De_out !== 1'b0) begin n_err++; $display("FAIL b2b_last_blank: got %b expected 0", De_out); end
                n_vec++; if (state !== RUN) begin n_err++; $display("FAIL b2b_state: got %0d expected %0d", state, RUN); end
                n_vec++; if (fifo_rd_en !== 1'b1) begin n_err++; $display("FAIL b2b_rd_en: got %b expected 1", fifo_rd_en); end
            end
        end
        n_vec++; if (De_out !== 1'b1) begin n_err++; $display("FAIL b2b_first_de: got %b expected 1", De_out); end
        n_vec++; if (Dout !== 24'd33) begin n_err++; $display("FAIL b2b_first_word: got %0d expected 33", Dout); end
        n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL b2b_fd_pulse: got %b expected 0", frame_done); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill_gate();
        test_alignment();
        test_underrun();
        test_enable_drop();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
